// File: rtl/mem_arb_pkg.sv
// Shared encodings, widths and request payload for the CPU/DMA memory port arbiter.
package mem_arb_pkg;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned GNT_W   = 2;
  localparam int unsigned LAT_W   = 3;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } arb_state_e;

  typedef enum logic [GNT_W-1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2
  } grant_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic mem_req_t pack_req(input logic              we,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata);
    mem_req_t r;
    r.we    = we;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction
endpackage

// File: rtl/mem_arb_starve.sv
// Fairness policy: saturating starvation counter and combinational winner select.
module mem_arb_starve
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_arb,
  input  logic i_cpu_req,
  input  logic i_dma_req,
  output logic o_dma_win_c
);
  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_at_limit;

  assign w_at_limit  = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign o_dma_win_c = i_dma_req && (!i_cpu_req || w_at_limit);

  // Counts CPU wins taken while the DMA was waiting; any DMA win clears it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else if (i_arb) begin
      if (o_dma_win_c) begin
        r_starve_cnt <= '0;
      end else if (i_cpu_req && i_dma_req && !w_at_limit) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between the CPU port and the DMA/IO port,
// one access at a time, with a req/done handshake per requester.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               CpuReq,
  input  logic               CpuWe,
  input  logic [ADDR_W-1:0]  CpuAddr,
  input  logic [DATA_W-1:0]  CpuWData,
  output logic [DATA_W-1:0]  CpuRData,
  output logic               CpuDone,
  input  logic               DmaReq,
  input  logic               DmaWe,
  input  logic [ADDR_W-1:0]  DmaAddr,
  input  logic [DATA_W-1:0]  DmaWData,
  output logic [DATA_W-1:0]  DmaRData,
  output logic               DmaDone,
  output logic               MemEn,
  output logic               MemWe,
  output logic [ADDR_W-1:0]  MemAddr,
  output logic [DATA_W-1:0]  MemWData,
  input  logic [DATA_W-1:0]  MemRData,
  output logic [GNT_W-1:0]   Grant,
  output logic [STATE_W-1:0] ArbState
);
  arb_state_e        r_state,      w_state_nxt;
  logic              r_owner_dma,  w_owner_dma_nxt;
  mem_req_t          r_req,        w_req_nxt;
  logic [LAT_W-1:0]  r_lat_cnt,    w_lat_cnt_nxt;
  logic              r_mem_en,     w_mem_en_nxt;
  logic              r_mem_we,     w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata,  w_mem_wdata_nxt;
  logic              r_cpu_done,   w_cpu_done_nxt;
  logic              r_dma_done,   w_dma_done_nxt;
  grant_e            r_grant,      w_grant_nxt;
  logic [DATA_W-1:0] r_cpu_rdata,  w_cpu_rdata_nxt;
  logic [DATA_W-1:0] r_dma_rdata,  w_dma_rdata_nxt;
  logic              w_dma_win;

  mem_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .i_clk      (CLK),
    .i_rst_n    (Reset),
    .i_arb      (r_state == IDLE),
    .i_cpu_req  (CpuReq),
    .i_dma_req  (DmaReq),
    .o_dma_win_c(w_dma_win)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_dma_nxt = r_owner_dma;
    w_req_nxt       = r_req;
    w_lat_cnt_nxt   = r_lat_cnt;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_dma_rdata_nxt = r_dma_rdata;

    unique case (r_state)
      IDLE: begin
        if (CpuReq || DmaReq) begin
          w_owner_dma_nxt = w_dma_win;
          w_req_nxt       = w_dma_win ? pack_req(DmaWe, DmaAddr, DmaWData)
                                      : pack_req(CpuWe, CpuAddr, CpuWData);
          w_state_nxt     = ACCESS;
        end
      end
      ACCESS: begin
        if (r_req.we) begin
          w_state_nxt = DONE;
        end else if (MEM_LAT == 1) begin
          w_state_nxt = CAPTURE;
        end else begin
          w_state_nxt   = WAIT;
          w_lat_cnt_nxt = LAT_W'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        if (r_lat_cnt <= LAT_W'(1)) begin
          w_state_nxt = CAPTURE;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
        end
      end
      CAPTURE: begin
        w_state_nxt = DONE;
        if (r_owner_dma) begin
          w_dma_rdata_nxt = MemRData;
        end else begin
          w_cpu_rdata_nxt = MemRData;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    w_mem_en_nxt    = (w_state_nxt == ACCESS);
    w_mem_we_nxt    = w_mem_en_nxt && w_req_nxt.we;
    w_mem_addr_nxt  = w_mem_en_nxt ? w_req_nxt.addr  : '0;
    w_mem_wdata_nxt = w_mem_en_nxt ? w_req_nxt.wdata : '0;
    w_cpu_done_nxt  = (w_state_nxt == DONE) && !w_owner_dma_nxt;
    w_dma_done_nxt  = (w_state_nxt == DONE) &&  w_owner_dma_nxt;
    if (w_state_nxt == IDLE) begin
      w_grant_nxt = GNT_NONE;
    end else begin
      w_grant_nxt = w_owner_dma_nxt ? GNT_DMA : GNT_CPU;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_owner_dma <= 1'b0;
      r_req       <= '0;
      r_lat_cnt   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_done  <= 1'b0;
      r_dma_done  <= 1'b0;
      r_grant     <= GNT_NONE;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner_dma <= w_owner_dma_nxt;
      r_req       <= w_req_nxt;
      r_lat_cnt   <= w_lat_cnt_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_cpu_done  <= w_cpu_done_nxt;
      r_dma_done  <= w_dma_done_nxt;
      r_grant     <= w_grant_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_dma_rdata <= w_dma_rdata_nxt;
    end
  end

  assign CpuRData = r_cpu_rdata;
  assign CpuDone  = r_cpu_done;
  assign DmaRData = r_dma_rdata;
  assign DmaDone  = r_dma_done;
  assign MemEn    = r_mem_en;
  assign MemWe    = r_mem_we;
  assign MemAddr  = r_mem_addr;
  assign MemWData = r_mem_wdata;
  assign Grant    = r_grant;
  assign ArbState = r_state;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters.
- Requester 0 is the CPU port (the control unit's MemRead/MemWrite, with the address muxed by IorD). Requester 1 is the DMA/IO port.
- Sits between the control-unit/datapath memory interface and the memory macro.
- Stretches CPU accesses with a req/done handshake so the control unit can hold in its stall states.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from the MemEn cycle to MemRData valid; legal range 1..7.
- STARVE_LIMIT, 4, consecutive CPU grants with DmaReq pending before the DMA is forced in; legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- CpuReq  in  1  CPU access request; held until CpuDone.
- CpuWe  in  1  1 = write, 0 = read; stable while CpuReq is high.
- CpuAddr  in  16  word address.
- CpuWData  in  16  write data.
- CpuRData  out  16  registered read data.
- CpuDone  out  1  one-cycle completion pulse.
- DmaReq, DmaWe, DmaAddr, DmaWData, DmaRData, DmaDone  same widths and meanings as the Cpu* ports, for the DMA requester.
- MemEn  out  1  memory access strobe, one cycle per access.
- MemWe  out  1  write enable; only ever high together with MemEn.
- MemAddr  out  16  memory address.
- MemWData  out  16  memory write data.
- MemRData  in  16  memory read data.
- Grant  out  2  current owner: 0 none, 1 CPU, 2 DMA.
- ArbState  out  3  current FSM state, for debug.

Behaviour:
- Reset:
  - Reset low at a rising edge puts the FSM in IDLE and sets StarveCnt=0.
  - CpuRData, DmaRData, all Done outputs, MemEn, MemWe, MemAddr, MemWData and Grant are all 0 after reset.
  - An access in flight when reset asserts is abandoned: no Done is issued and no RData is updated.
- States:
  - IDLE: arbitrates.
  - ACCESS: drives MemEn.
  - WAIT: counts the read latency.
  - CAPTURE: registers the read data.
  - DONE: pulses the owner's Done.
- IDLE:
  - With no request, stay in IDLE, Grant=0.
  - With one request, grant that requester.
  - With both requesting, the CPU wins unless StarveCnt==STARVE_LIMIT, in which case the DMA wins.
  - The winner's We/Addr/WData are latched into internal registers. Go to ACCESS; Grant takes the new owner from the next cycle.
- StarveCnt:
  - Increments, saturating at STARVE_LIMIT, on every CPU grant made while DmaReq is high.
  - Clears on every DMA grant.
- ACCESS:
  - MemEn=1, MemWe=latched We, MemAddr/MemWData = latched values, for exactly one cycle.
  - A write goes next to DONE.
  - A read goes to WAIT with a counter loaded to MEM_LAT-1; if MEM_LAT==1 it goes straight to CAPTURE.
- WAIT: decrement the counter; go to CAPTURE when it reaches 1.
- CAPTURE: MemRData is valid in this cycle and is registered into the owner's RData at the cycle end. The other requester's RData is unchanged.
- DONE: the owner's Done=1 for one cycle, then go to IDLE. Grant returns to 0 in IDLE.
- Latency, counting the cycle IDLE samples Req as cycle 0:
  - Write: MemEn in cycle 1, Done in cycle 2.
  - Read: MemEn in cycle 1, Done in cycle MEM_LAT+2, with RData valid in the Done cycle and held until that requester's next read completes.
- Handshake rules:
  - A requester must keep Req and its attributes stable from assertion until its Done.
  - Req still high in the cycle after Done is a new request.
  - Dropping Req before Done is illegal; it is covered by a bench assertion, and the access completes regardless.
- Mem* outputs when not in ACCESS: MemEn=0, MemWe=0, MemAddr=0, MemWData=0.
- Simultaneous events: a request arriving during a busy access waits, and is arbitrated in the next IDLE cycle. There is one access at a time and no pipelining.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encodings: IDLE=0, ACCESS=1, WAIT=2, CAPTURE=3, DONE=4;
  - the Grant encodings: GNT_NONE=0, GNT_CPU=1, GNT_DMA=2;
  - the width constants ADDR_W=16, DATA_W=16.
- One sub-module, mem_arb_starve: the saturating StarveCnt plus the combinational winner select. It keeps the fairness policy separately testable.

Test Plan:
- Reset low for 2 cycles during a DMA read in WAIT -> no DmaDone, all outputs 0, FSM in IDLE; the first CPU read after release completes with CpuDone in cycle 3 (MEM_LAT=1).
- CPU write addr 0x0010 data 0xBEEF -> MemEn=MemWe=1 in cycle 1 with MemAddr=0x0010 and MemWData=0xBEEF; CpuDone in cycle 2.
- CPU read addr 0x0010 with MEM_LAT=3, memory returning 0xBEEF -> CpuDone in cycle 5, CpuRData=0xBEEF; DmaRData unchanged.
- CpuReq and DmaReq both held continuously (STARVE_LIMIT=4) -> grant order is CPU,CPU,CPU,CPU,DMA, repeating; StarveCnt reads 0 after each DMA grant.
- DmaReq asserted during a CPU read -> the DMA access starts in the IDLE cycle after CpuDone, and MemEn is never high in two overlapping accesses.
- Back-to-back CPU writes with CpuReq held high through CpuDone -> second MemEn 3 cycles after the first.
